twos_to_signmag_serial: RTL and testbench

- Multi-cycle decoder that converts a two's-complement word into sign-magnitude form. It is the inverse direction of the CPU's combinational negation path.
- Sits between the register-file read port and the multiply/divide datapath, which operates on magnitudes.
- Works digit-serially, LSB first, using the copy-until-first-one-then-invert rule.
- Valid/ready handshake on both the input and the output side.

---
 rtl/twos_to_signmag_serial.sv | 119 +++++++++++
 tb/tb_twos_to_signmag_serial.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/twos_to_signmag_serial.sv
// Digit-serial two's-complement to sign-magnitude converter, LSB first, using
// the copy-until-first-one-then-invert rule. Valid/ready on both sides.
module twos_to_signmag_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_zero,
  output logic             busy
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] mag_r;
  logic [WIDTH-1:0] mag_shift;
  logic             sign_r;
  logic             zero_r;
  logic             seen_one;
  logic             seen_nxt;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dig;
  logic             accept;
  logic             last_dig;

  assign out_sign = sign_r;
  assign out_mag  = mag_r;
  assign out_zero = zero_r;

  assign last_dig  = (state == RUN) && (cnt == CW'(NDIG - 1));
  assign mag_shift = {dig, mag_r[WIDTH-1:DIGIT]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = in_data[WIDTH-1] ? RUN : DONE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_dig) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // seen_one ripples through the digit so a 1 in a low bit inverts the higher bits
  always_comb begin
    seen_nxt = seen_one;
    dig      = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dig[i]   = seen_nxt ? ~sr[i] : sr[i];
      seen_nxt = seen_nxt | sr[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      mag_r    <= '0;
      sign_r   <= 1'b0;
      zero_r   <= 1'b0;
      seen_one <= 1'b0;
      cnt      <= '0;
    end else if (accept) begin
      sr       <= in_data;
      sign_r   <= in_data[WIDTH-1];
      cnt      <= '0;
      seen_one <= 1'b0;
      if (!in_data[WIDTH-1]) begin
        mag_r  <= in_data;
        zero_r <= ~|in_data;
      end else begin
        zero_r <= 1'b0;
      end
    end else if (state == RUN) begin
      sr       <= sr >> DIGIT;
      mag_r    <= mag_shift;
      seen_one <= seen_nxt;
      cnt      <= cnt + CW'(1);
      if (last_dig) zero_r <= ~|mag_shift;
    end
  end

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Scoreboard bench for twos_to_signmag_serial: directed latency, boundary,
// backpressure and reset cases, then a randomised handshake stream.
module tb_twos_to_signmag_serial;

  localparam int unsigned WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_sign;
  logic [WIDTH-1:0] out_mag;
  logic             out_zero;
  logic             busy;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned nres = 0;
  logic        mon_en = 1'b0;
  logic        prod_done = 1'b0;
  logic [33:0] q[$];

  twos_to_signmag_serial #(.WIDTH(WIDTH), .DIGIT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mag(out_mag), .out_zero(out_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] ref_conv(input logic [31:0] x);
    return {x[31], (x == 32'd0), (x[31] ? (~x + 32'd1) : x)};
  endfunction

  function automatic logic [63:0] res();
    return 64'({out_sign, out_zero, out_mag});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one directed transaction with exact latency and optional backpressure
  task automatic run_one(input logic [31:0] x, input int unsigned hold);
    logic [33:0] e;
    int unsigned lat;
    e = ref_conv(x);
    lat = x[31] ? 8 : 0;
    out_ready = (hold == 0);
    in_valid = 1'b1;
    in_data = x;
    tick();
    in_valid = 1'b0;
    for (int unsigned k = 0; k < lat; k++) begin
      check("run_busy", 64'(busy), 64'd1);
      check("run_novalid", 64'(out_valid), 64'd0);
      tick();
    end
    check("done_valid", 64'(out_valid), 64'd1);
    check("done_result", res(), 64'(e));
    for (int unsigned h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data = $urandom;
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_inready", 64'(in_ready), 64'd0);
      check("hold_result", res(), 64'(e));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("release_idle", 64'(in_ready), 64'd1);
    check("release_novalid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      nres++;
      check("stream_expected", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) check("stream_result", res(), 64'(q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_valid;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_inready", 64'(in_ready), 64'd1);
    check("rst_outs", 64'({out_valid, busy, out_sign, out_zero, out_mag}), 64'd0);
    rst = 1'b0;
    tick();

    run_one(32'h0000_0020, 0);
    run_one(32'hFFFF_FFE0, 0);
    run_one(32'hFFFF_FFFF, 0);
    run_one(32'h8000_0000, 0);
    run_one(32'h0000_0000, 0);
    run_one(32'hFFFF_FFF9, 5);

    // asynchronous reset with no clock edge while a result is pending
    in_valid = 1'b1;
    in_data = 32'h0000_1234;
    tick();
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_inready", 64'(in_ready), 64'd1);
    check("async_outs", 64'({out_valid, busy, out_sign, out_zero, out_mag}), 64'd0);
    rst = 1'b0;
    tick();

    // reset partway through the serial conversion
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFE0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrun_inready", 64'(in_ready), 64'd1);
    check("midrun_busy", 64'(busy), 64'd0);
    #1 rst = 1'b0;
    saw_valid = 1'b0;
    for (int unsigned k = 0; k < 12; k++) begin
      tick();
      saw_valid = saw_valid | out_valid;
    end
    check("midrun_novalid", 64'(saw_valid), 64'd0);
    out_ready = 1'b0;

    mon_en = 1'b1;
    fork
      begin : producer
        logic [31:0] x;
        logic acc;
        int unsigned waited;
        int unsigned r;
        for (int unsigned n = 0; n < 1000; n++) begin
          repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data = $urandom;
            tick();
          end
          r = $urandom_range(0, 15);
          x = (r == 0) ? 32'h0000_0000 : (r == 1) ? 32'h8000_0000 :
              (r == 2) ? 32'hFFFF_FFFF : 32'($urandom);
          in_valid = 1'b1;
          in_data = x;
          waited = 0;
          do begin
            acc = in_ready;
            tick();
            waited++;
          end while (!acc && waited < 200);
          if (!acc) begin
            check("accept_timeout", 64'(acc), 64'd1);
            break;
          end
          q.push_back(ref_conv(x));
          in_valid = 1'b0;
          in_data = $urandom;
        end
        prod_done = 1'b1;
      end
      begin : consumer
        int unsigned cyc;
        cyc = 0;
        while (!(prod_done && q.size() == 0) && cyc < 60000) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    tick();
    mon_en = 1'b0;
    check("stream_drained", 64'(q.size()), 64'd0);
    check("stream_count", 64'(nres), 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
